mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: LoadReq in 1 load request; StoreReq in 1 store request; Addr in 32 byte address; WriteData in 32 store data; WidthSrc in 3 width code.
REQ-004 SHALL have ports: Stall out 1 pipeline hold; LoadResult out 32 reduced load data; Fault out 1 illegal-access pulse.
REQ-005 SHALL have bus ports: BusReq out 1; BusWe out 1; BusAddr out 32 word-aligned; BusWData out 32; BusByteEn out 4; BusReady in 1; BusRData in 32.

Function
REQ-006 SHALL decode WidthSrc as: 000 word; 010 half signed; 110 half unsigned; 001 byte signed; 101 byte unsigned; other codes illegal. Stores ignore WidthSrc[2].
REQ-007 SHALL implement FSM states IDLE, ACCESS0, ACCESS1 and DONE.
REQ-008 IDLE: exactly one of LoadReq/StoreReq high with legal access -> ACCESS0. Illegal code, both requests high, or unsupported misalignment -> DONE with Fault.
REQ-009 Stall SHALL be high combinationally in IDLE while any request is high, and in ACCESS0/ACCESS1. Stall SHALL be low in DONE.
REQ-010 Access parameters SHALL be latched at acceptance: Addr, WriteData, WidthSrc, direction. The pipeline inputs are ignored until IDLE returns.
REQ-011 ACCESS0: BusReq=1, BusAddr={Addr[31:2],2'b00}, signals held stable until BusReady. On BusReady, BusRData SHALL be captured as the low word, then -> ACCESS1 if the access is split, else -> DONE.
REQ-012 ACCESS1: BusReq=1, BusAddr=first address+4, upper lanes only. On BusReady, data SHALL be captured as the high word, then -> DONE.
REQ-013 Misaligned SHALL mean: half with Addr[0]=1, or word with Addr[1:0]!=00. A split SHALL be an access whose bytes cross the word boundary.
REQ-014 Load assembly SHALL form {high,low} (high=0 if unsplit), shift right by 8*Addr[1:0], then sign- or zero-extend the low 8/16/32 bits per WidthSrc.
REQ-015 Store SHALL drive BusWe=1 with BusWData=WriteData<<8*Addr[1:0] and BusByteEn=mask<<Addr[1:0], where mask is 0001/0011/1111. Lanes beyond bit 3 go to the ACCESS1 beat, shifted down by 4 lanes.
REQ-016 DONE SHALL last one cycle, then -> IDLE. For loads, LoadResult SHALL be registered and held until the next load completes. Fault SHALL be high in DONE only for rejected requests.
REQ-017 BusReq, BusWe and BusByteEn SHALL be 0 in IDLE and DONE. A rejected request SHALL issue no bus beat.
REQ-018 Minimum latency with BusReady tied high: aligned access = 3 cycles (IDLE, ACCESS0, DONE). Split access = 4 cycles. Each BusReady-low cycle SHALL add one cycle.

Reset
REQ-019 reset SHALL immediately force IDLE and the following outputs to zero: BusReq, BusWe, BusByteEn, BusAddr, BusWData, LoadResult, Fault, latched registers.
REQ-020 reset mid-transaction SHALL abort it with no DONE cycle and no partial LoadResult update. A late BusReady SHALL be ignored.

Configuration
REQ-021 Macro MISALIGNED_SPLIT_EN defined: misaligned accesses SHALL proceed per REQ-011..REQ-015 as one or two beats.
REQ-022 MISALIGNED_SPLIT_EN undefined: ACCESS1 SHALL be absent. Any misaligned access SHALL go IDLE->DONE with Fault=1 and no bus beat.

Verification
REQ-023 Load Addr=0x100, WidthSrc=001, BusRData=0x000000F0, BusReady=1 -> BusAddr=0x100, LoadResult=0xFFFFFFF0, Stall high 2 cycles.
REQ-024 Load Addr=0x102, WidthSrc=110, BusRData=0x8001ABCD, BusReady low 2 cycles -> LoadResult=0x00008001, total 5 cycles.
REQ-025 Store Addr=0x203, WidthSrc=000, WriteData=0x11223344 with macro -> beat1 0x200/ByteEn 1000/data 0x44000000; beat2 0x204/ByteEn 0111/data 0x00112233. Without macro -> Fault=1, no BusReq.
REQ-026 WidthSrc=011, or LoadReq and StoreReq both high -> Fault pulse 1 cycle, no BusReq, LoadResult unchanged.
REQ-027 reset asserted in ACCESS0 while BusReq=1 -> BusReq=0 same cycle, state IDLE, LoadResult=0, next request serviced normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Memory bus bundle between mem_access_ctrl (master) and a word-wide memory port (slave).
interface mem_access_ctrl_if;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [3:0]  BusByteEn;
  logic        BusReady;
  logic [31:0] BusRData;

  modport master (
    output BusReq, BusWe, BusAddr, BusWData, BusByteEn,
    input  BusReady, BusRData
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusWData, BusByteEn,
    output BusReady, BusRData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: turns one pipeline load or store into one or two
// word-aligned bus beats, assembles and extends load data, and flags illegal accesses.
// Build option MISALIGNED_SPLIT_EN: misaligned accesses are carried out (two beats when
// the bytes straddle a word boundary); without it every misaligned access faults.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        LoadReq,
  input  logic        StoreReq,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  WidthSrc,
  output logic        Stall,
  output logic [31:0] LoadResult,
  output logic        Fault,
  mem_access_ctrl_if.master bus
);

  localparam int unsigned DataW = 32;
  localparam int unsigned WordLanes = 4;
`ifdef MISALIGNED_SPLIT_EN
  localparam int unsigned LaneW = 2 * WordLanes;
`else
  localparam int unsigned LaneW = WordLanes;
`endif
  localparam int unsigned SpanW = 8 * LaneW;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS0 = 2'd1;
`ifdef MISALIGNED_SPLIT_EN
  localparam logic [1:0] ACCESS1 = 2'd2;
`endif
  localparam logic [1:0] DONE    = 2'd3;

  // Width code legality; stores only look at the size bits
  function automatic logic codeLegal(input logic [2:0] code, input logic isStore);
    return (code[1:0] != 2'b11) && (isStore || !(code[2] && (code[1:0] == 2'b00)));
  endfunction

  // Byte-lane mask of an access at lane 0
  function automatic logic [3:0] laneMask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b1111;
      2'b10:   m = 4'b0011;
      default: m = 4'b0001;
    endcase
    return m;
  endfunction

  // Store data moved onto its byte lanes (two words wide when splitting is built in)
  function automatic logic [SpanW-1:0] spanData(input logic [1:0] off, input logic [DataW-1:0] data);
    return SpanW'(data) << {off, 3'b000};
  endfunction

  // Byte enables moved onto their lanes
  function automatic logic [LaneW-1:0] spanEn(input logic [1:0] off, input logic [1:0] size);
    return LaneW'(laneMask(size)) << off;
  endfunction

`ifdef MISALIGNED_SPLIT_EN
  // True when the access bytes run past the end of the first word
  function automatic logic crossesWord(input logic [1:0] off, input logic [1:0] size);
    logic [2:0] cnt;
    case (size)
      2'b00:   cnt = 3'd4;
      2'b10:   cnt = 3'd2;
      default: cnt = 3'd1;
    endcase
    return (3'(off) + cnt) > 3'd4;
  endfunction
`else
  // Halves must be 2-byte aligned and words 4-byte aligned
  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
    return ((size == 2'b10) && off[0]) || ((size == 2'b00) && (off != 2'b00));
  endfunction
`endif

  logic [1:0]       state, nextState;
  logic [DataW-1:0] addrQ, wdataQ;
  logic [2:0]       widthQ;
  logic             storeQ;
`ifdef MISALIGNED_SPLIT_EN
  logic             splitQ;
  logic [DataW-1:0] lowWordQ;
  logic [2*DataW-1:0] fullWord;
`endif

  logic             busReqQ, busWeQ, faultQ;
  logic [DataW-1:0] busAddrQ, busWDataQ, loadResultQ;
  logic [3:0]       busByteEnQ;

  logic             busReqNxt, busWeNxt, faultNxt, loadDone;
  logic [DataW-1:0] busAddrNxt, busWDataNxt;
  logic [3:0]       busByteEnNxt;

  logic             anyReq, accept;
  logic [1:0]       selOff;
  logic [1:0]       selSize;
  logic [DataW-1:0] selData;
  logic [SpanW-1:0] span;
  logic [LaneW-1:0] spanLanes;
  logic [DataW-1:0] firstWord;
  logic [DataW-1:0] rawWord, loadValue;

  // Request qualification and lane placement (live inputs in IDLE, latched values after)
  always_comb begin
    anyReq = LoadReq | StoreReq;
    accept = (LoadReq ^ StoreReq) && codeLegal(WidthSrc, StoreReq);
`ifndef MISALIGNED_SPLIT_EN
    if (misaligned(Addr[1:0], WidthSrc[1:0])) accept = 1'b0;
`endif
    selOff    = (state == IDLE) ? Addr[1:0]     : addrQ[1:0];
    selSize   = (state == IDLE) ? WidthSrc[1:0] : widthQ[1:0];
    selData   = (state == IDLE) ? WriteData     : wdataQ;
    span      = spanData(selOff, selData);
    spanLanes = spanEn(selOff, selSize);
    firstWord = {addrQ[DataW-1:2], 2'b00};
  end

  // Next state and next values of the registered bus/fault outputs
  always_comb begin
    nextState    = state;
    busReqNxt    = 1'b0;
    busWeNxt     = 1'b0;
    busByteEnNxt = '0;
    busAddrNxt   = busAddrQ;
    busWDataNxt  = busWDataQ;
    faultNxt     = 1'b0;
    loadDone     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState    = ACCESS0;
          busReqNxt    = 1'b1;
          busWeNxt     = StoreReq;
          busAddrNxt   = {Addr[DataW-1:2], 2'b00};
          busWDataNxt  = StoreReq ? span[DataW-1:0] : '0;
          busByteEnNxt = spanLanes[WordLanes-1:0];
        end else if (anyReq) begin
          nextState = DONE;
          faultNxt  = 1'b1;
        end
      end
      ACCESS0: begin
        busReqNxt    = 1'b1;
        busWeNxt     = storeQ;
        busAddrNxt   = firstWord;
        busWDataNxt  = storeQ ? span[DataW-1:0] : '0;
        busByteEnNxt = spanLanes[WordLanes-1:0];
        if (bus.BusReady) begin
`ifdef MISALIGNED_SPLIT_EN
          if (splitQ) begin
            nextState    = ACCESS1;
            busAddrNxt   = firstWord + DataW'(4);
            busWDataNxt  = storeQ ? span[2*DataW-1:DataW] : '0;
            busByteEnNxt = spanLanes[LaneW-1:WordLanes];
          end else begin
            nextState    = DONE;
            busReqNxt    = 1'b0;
            busWeNxt     = 1'b0;
            busByteEnNxt = '0;
            loadDone     = !storeQ;
          end
`else
          nextState    = DONE;
          busReqNxt    = 1'b0;
          busWeNxt     = 1'b0;
          busByteEnNxt = '0;
          loadDone     = !storeQ;
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ACCESS1: begin
        busReqNxt    = 1'b1;
        busWeNxt     = storeQ;
        busAddrNxt   = firstWord + DataW'(4);
        busWDataNxt  = storeQ ? span[2*DataW-1:DataW] : '0;
        busByteEnNxt = spanLanes[LaneW-1:WordLanes];
        if (bus.BusReady) begin
          nextState    = DONE;
          busReqNxt    = 1'b0;
          busWeNxt     = 1'b0;
          busByteEnNxt = '0;
          loadDone     = !storeQ;
        end
      end
`endif
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Load assembly: {high,low}, shift to the addressed byte, then extend
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    if (state == ACCESS1) fullWord = {bus.BusRData, lowWordQ};
    else                  fullWord = {{DataW{1'b0}}, bus.BusRData};
    rawWord = DataW'(fullWord >> {addrQ[1:0], 3'b000});
`else
    rawWord = bus.BusRData >> {addrQ[1:0], 3'b000};
`endif
    case (widthQ[1:0])
      2'b10:   loadValue = widthQ[2] ? {16'h0000, rawWord[15:0]}
                                     : {{16{rawWord[15]}}, rawWord[15:0]};
      2'b01:   loadValue = widthQ[2] ? {24'h000000, rawWord[7:0]}
                                     : {{24{rawWord[7]}}, rawWord[7:0]};
      default: loadValue = rawWord;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Access parameters latched at acceptance; first beat kept for split loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrQ    <= '0;
      wdataQ   <= '0;
      widthQ   <= '0;
      storeQ   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      splitQ   <= 1'b0;
      lowWordQ <= '0;
`endif
    end else begin
      if ((state == IDLE) && accept) begin
        addrQ  <= Addr;
        wdataQ <= WriteData;
        widthQ <= WidthSrc;
        storeQ <= StoreReq;
`ifdef MISALIGNED_SPLIT_EN
        splitQ <= crossesWord(Addr[1:0], WidthSrc[1:0]);
`endif
      end
`ifdef MISALIGNED_SPLIT_EN
      if ((state == ACCESS0) && bus.BusReady) lowWordQ <= bus.BusRData;
`endif
    end
  end

  // Registered bus, fault and load-result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busReqQ     <= 1'b0;
      busWeQ      <= 1'b0;
      busAddrQ    <= '0;
      busWDataQ   <= '0;
      busByteEnQ  <= '0;
      faultQ      <= 1'b0;
      loadResultQ <= '0;
    end else begin
      busReqQ    <= busReqNxt;
      busWeQ     <= busWeNxt;
      busAddrQ   <= busAddrNxt;
      busWDataQ  <= busWDataNxt;
      busByteEnQ <= busByteEnNxt;
      faultQ     <= faultNxt;
      if (loadDone) loadResultQ <= loadValue;
    end
  end

  // Pipeline hold: request pending in IDLE or a bus beat in flight
  always_comb begin
    Stall = ((state == IDLE) && anyReq) || (state == ACCESS0);
`ifdef MISALIGNED_SPLIT_EN
    if (state == ACCESS1) Stall = 1'b1;
`endif
  end

  assign bus.BusReq    = busReqQ;
  assign bus.BusWe     = busWeQ;
  assign bus.BusAddr   = busAddrQ;
  assign bus.BusWData  = busWDataQ;
  assign bus.BusByteEn = busByteEnQ;
  assign LoadResult    = loadResultQ;
  assign Fault         = faultQ;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized bench for mem_access_ctrl against a byte-level access model.
// Honours MISALIGNED_SPLIT_EN the same way as the design build.
module tb_mem_access_ctrl;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        LoadReq, StoreReq;
  logic [31:0] Addr, WriteData;
  logic [2:0]  WidthSrc;
  logic        Stall, Fault;
  logic [31:0] LoadResult;

  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .LoadReq   (LoadReq),
    .StoreReq  (StoreReq),
    .Addr      (Addr),
    .WriteData (WriteData),
    .WidthSrc  (WidthSrc),
    .Stall     (Stall),
    .LoadResult(LoadResult),
    .Fault     (Fault),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expLoad = 32'h0;
  logic [7:0]  memOv [logic [31:0]];

  int          lastCycles, lastStall, lastBeats;
  logic        lastFault;
  logic [31:0] obsAddr [2];
  logic [31:0] obsData [2];
  logic [3:0]  obsEn   [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory contents seen by the bus slave: overrides first, otherwise a byte hash
  function automatic logic [7:0] memByte(input logic [31:0] a);
    if (memOv.exists(a)) return memOv[a];
    return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] w);
    return {memByte(w + 32'd3), memByte(w + 32'd2), memByte(w + 32'd1), memByte(w)};
  endfunction

  // Bytes moved by an access, 0 when the request itself is illegal
  function automatic int accessSize(input logic ld, input logic st, input logic [2:0] w);
    if (ld == st) return 0;
    if (st) begin
      case (w[1:0])
        2'b00:   return 4;
        2'b10:   return 2;
        2'b01:   return 1;
        default: return 0;
      endcase
    end
    case (w)
      3'b000:         return 4;
      3'b010, 3'b110: return 2;
      3'b001, 3'b101: return 1;
      default:        return 0;
    endcase
  endfunction

  function automatic void setWord(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) memOv[a + 32'(i)] = d[8*i +: 8];
  endfunction

  // One pipeline request with per-beat BusReady wait states; checks every cycle
  task automatic runAccess(input logic ld, input logic st, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] w,
                           input int dly0, input int dly1);
    int          size, nBeats, k, guard, cyc, stallCyc, dl, rel, expCyc;
    logic        ok;
    logic [31:0] firstW, val;
    logic [31:0] expAddr [2];
    logic [31:0] expData [2];
    logic [3:0]  expEn   [2];

    size   = accessSize(ld, st, w);
    ok     = (size != 0) && (SplitEn || ((int'(a[1:0]) % size) == 0));
    firstW = {a[31:2], 2'b00};
    nBeats = ok ? (((int'(a[1:0]) + size) > 4) ? 2 : 1) : 0;
    for (int b = 0; b < 2; b++) begin
      expAddr[b] = firstW + 32'(4 * b);
      expEn[b]   = '0;
      expData[b] = '0;
      for (int i = 0; i < 4; i++) begin
        rel = 4 * b + i - int'(a[1:0]);
        if (rel >= 0 && rel < size) expEn[b][i] = 1'b1;
        if (rel >= 0 && rel < 4)    expData[b][8*i +: 8] = wd[8*rel +: 8];
      end
    end
    val = '0;
    for (int i = 0; i < size; i++) val[8*i +: 8] = memByte(a + 32'(i));
    if (!w[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
    if (!w[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
    expCyc = ok ? (2 + nBeats + dly0 + ((nBeats == 2) ? dly1 : 0)) : 2;

    @(negedge clk);
    LoadReq = ld; StoreReq = st; Addr = a; WriteData = wd; WidthSrc = w;
    #1;
    chk("stall_idle_req", Stall, 1);
    stallCyc = (Stall === 1'b1) ? 1 : 0;
    cyc = 1;
    @(negedge clk);
    LoadReq = 0; StoreReq = 0;
    Addr = $urandom; WriteData = $urandom; WidthSrc = 3'($urandom);

    k = 0; guard = 0; dl = dly0;
    while (bus.BusReq === 1'b1 && guard < 16) begin
      guard++; cyc++;
      if (Stall === 1'b1) stallCyc++;
      if (k < 2) begin
        obsAddr[k] = bus.BusAddr; obsData[k] = bus.BusWData; obsEn[k] = bus.BusByteEn;
      end
      if (k < nBeats) begin
        chk("beat_addr", bus.BusAddr, expAddr[k]);
        chk("beat_we", bus.BusWe, st);
        if (st) begin
          chk("beat_byteen", bus.BusByteEn, expEn[k]);
          chk("beat_wdata", bus.BusWData, expData[k]);
        end
      end
      if (dl > 0) begin
        bus.BusReady = 1'b0; bus.BusRData = $urandom; dl--;
      end else begin
        bus.BusReady = 1'b1; bus.BusRData = memWord(bus.BusAddr); k++; dl = dly1;
      end
      @(negedge clk);
    end
    bus.BusReady = 1'b0;
    cyc++;
    chk("beat_timeout", guard < 16, 1);
    chk("beat_count", k, nBeats);
    chk("latency", cyc, expCyc);
    chk("done_fault", Fault, !ok);
    chk("done_stall", Stall, 0);
    chk("done_busreq", bus.BusReq, 0);
    chk("done_buswe", bus.BusWe, 0);
    chk("done_byteen", bus.BusByteEn, 0);
    if (ld && ok) expLoad = val;
    chk("load_result", LoadResult, expLoad);
    lastCycles = cyc; lastStall = stallCyc; lastBeats = k; lastFault = Fault;
    @(negedge clk);
    chk("idle_fault", Fault, 0);
    chk("idle_load_hold", LoadResult, expLoad);
  endtask

  logic [2:0] legalCodes [5] = '{3'b000, 3'b010, 3'b110, 3'b001, 3'b101};

  initial begin
    int          kind;
    logic        rl, rs;
    logic [2:0]  rw;
    logic [31:0] ra, rd;

    reset = 1'b1; LoadReq = 0; StoreReq = 0; Addr = 0; WriteData = 0; WidthSrc = 0;
    bus.BusReady = 1'b0; bus.BusRData = '0;
    repeat (2) @(negedge clk);
    chk("rst_busreq", bus.BusReq, 0);
    chk("rst_buswe", bus.BusWe, 0);
    chk("rst_byteen", bus.BusByteEn, 0);
    chk("rst_busaddr", bus.BusAddr, 0);
    chk("rst_buswdata", bus.BusWData, 0);
    chk("rst_loadresult", LoadResult, 0);
    chk("rst_fault", Fault, 0);
    chk("rst_stall", Stall, 0);
    reset = 1'b0;

    // Signed byte load, zero wait states
    setWord(32'h100, 32'h000000F0);
    runAccess(1, 0, 32'h100, 32'h0, 3'b001, 0, 0);
    chk("v1_result", LoadResult, 32'hFFFFFFF0);
    chk("v1_addr", obsAddr[0], 32'h100);
    chk("v1_stall_cycles", lastStall, 2);
    chk("v1_cycles", lastCycles, 3);

    // Unsigned upper-half load with two wait states
    setWord(32'h100, 32'h8001ABCD);
    runAccess(1, 0, 32'h102, 32'h0, 3'b110, 2, 0);
    chk("v2_result", LoadResult, 32'h00008001);
    chk("v2_cycles", lastCycles, 5);

    // Word store straddling a word boundary
    runAccess(0, 1, 32'h203, 32'h11223344, 3'b000, 0, 0);
`ifdef MISALIGNED_SPLIT_EN
    chk("v3_beats", lastBeats, 2);
    chk("v3_addr0", obsAddr[0], 32'h200);
    chk("v3_en0", obsEn[0], 4'b1000);
    chk("v3_data0", obsData[0], 32'h44000000);
    chk("v3_addr1", obsAddr[1], 32'h204);
    chk("v3_en1", obsEn[1], 4'b0111);
    chk("v3_data1", obsData[1], 32'h00112233);
    chk("v3_cycles", lastCycles, 4);
`else
    chk("v3_beats", lastBeats, 0);
    chk("v3_fault", lastFault, 1);
`endif

    // Illegal width code and double request
    runAccess(1, 0, 32'h300, 32'h0, 3'b011, 0, 0);
    chk("v4_fault", lastFault, 1);
    chk("v4_beats", lastBeats, 0);
    chk("v4_result_kept", LoadResult, 32'h00008001);
    runAccess(1, 1, 32'h304, 32'hDEADBEEF, 3'b000, 0, 0);
    chk("v4b_fault", lastFault, 1);
    chk("v4b_result_kept", LoadResult, 32'h00008001);

    // Reset while the first beat is waiting for BusReady
    @(negedge clk);
    LoadReq = 1; Addr = 32'h400; WidthSrc = 3'b000;
    @(negedge clk);
    LoadReq = 0;
    chk("v5_busreq_before", bus.BusReq, 1);
    #2 reset = 1'b1;
    #1;
    chk("v5_busreq_reset", bus.BusReq, 0);
    chk("v5_result_reset", LoadResult, 0);
    chk("v5_busaddr_reset", bus.BusAddr, 0);
    chk("v5_stall_reset", Stall, 0);
    expLoad = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    bus.BusReady = 1'b1; bus.BusRData = 32'hCAFEF00D;
    @(negedge clk);
    chk("v5_late_ready_busreq", bus.BusReq, 0);
    chk("v5_late_ready_fault", Fault, 0);
    chk("v5_late_ready_result", LoadResult, 0);
    bus.BusReady = 1'b0;
    runAccess(1, 0, 32'h404, 32'h0, 3'b000, 1, 0);

    // Randomized mix of loads, stores and illegal requests
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      rl = (kind < 5) || (kind == 9);
      rs = (kind >= 5);
      rw = ($urandom_range(0, 4) == 0) ? 3'($urandom) : legalCodes[$urandom_range(0, 4)];
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = {30'h3FFFFFFF, 2'($urandom)};
      rd = $urandom;
      runAccess(rl, rs, ra, rd, rw, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
